cr_xer_wb: RTL and testbench
============================

// Module: cr_xer_wb
// PURPOSE
//  Architected CR/XER state unit; the consumer end of the ALU flag bus and the producer of its CRrd/XERrd inputs.
//  Latches ALU flags {CA,OV,LT0,GT0,EQ0,LT,GT,EQ} into XER and the selected CR field each cycle an update is valid.
//  Also executes mtcrf, mcrf, mcrxr, mtxer and the eight CR-logical ops. Sits at the writeback stage.
// PARAMETERS
//  CR_RST   32'h0000_0000  CR value after reset
//  XER_RST  32'h0000_0000  XER value after reset
// PORTS
//  clk       in   1   clock, all state updates on rising edge
//  rst_n     in   1   reset, asynchronous, active-low
//  wbValid   in   1   qualifies every write input this cycle
//  aluD      in   8   ALU flag bus {CA,OV,LT0,GT0,EQ0,LTx,GTx,EQx}, bit 0 = CA
//  crOp      in   4   CROp_NOP/REC/CMP/MTCRF/MCRF/MCRXR/LOGIC (ctrl_encode_def.v)
//  crLogic   in   3   LOGIC subop: AND,OR,XOR,NAND,NOR,EQV,ANDC,ORC
//  caWr      in   1   write XER[CA] from aluD[0]
//  ovWr      in   1   write XER[OV] from aluD[1], OR into XER[SO]
//  xerWr     in   1   mtxer: XER <= gprIn (masked to implemented bits)
//  crfD      in   3   destination CR field (REC ignores; uses field 0)
//  crfS      in   3   source field for MCRF
//  crbA,crbB,crbD in 5 each  CR bit indices for LOGIC
//  fxm       in   8   MTCRF field mask, fxm[i] selects CR field i
//  gprIn     in   32  GPR source for MTCRF/mtxer
//  CRrd      out  32  current CR, big-endian [0:31]
//  XERrd     out  32  current XER; SO=0, OV=1, CA=2, count=25:31; others read 0
// BEHAVIOUR
//  - Reset (async, rst_n low): CR<=CR_RST, XER<=XER_RST&implemented mask; outputs follow within same delta. Reset mid-update discards it.
//  - wbValid=0: no state change regardless of other inputs.
//  - XER next: start from current; xerWr has priority over caWr/ovWr (flags ignored that cycle).
//    caWr: CA<=aluD[0]. ovWr: OV<=aluD[1]; SO<=SO|aluD[1] (sticky, only cleared by xerWr or MCRXR).
//  - SO_new = next-cycle SO computed above; all CR-field writes using SO use SO_new (same-cycle OV visible).
//  - REC: CR[0:3] <= {aluD[2:4], SO_new}. CMP: CR field crfD <= {aluD[5:7], SO_new}.
//  - MTCRF: for each i with fxm[i]=1, CR[4i:4i+3] <= gprIn[4i:4i+3]; fxm=0 -> no change.
//  - MCRF: field crfD <= field crfS (old value); crfD==crfS -> unchanged.
//  - MCRXR: field crfD <= XER[0:3] (old); XER[0:3] <= 0; overrides concurrent caWr/ovWr on those bits.
//  - LOGIC: CR[crbD] <= f(CR[crbA],CR[crbB]) using old CR; crbA==crbB==crbD legal.
//  - crOp and XER flag writes in one cycle are independent except rules above; undefined crOp = NOP.
//  - Latency: one cycle; value written at edge N visible on CRrd/XERrd after edge N.
// CONFIGURATION
//  - CRXER_BYPASS_EN defined: CRrd/XERrd present the next-state value combinationally when wbValid=1
//    (zero-latency forwarding to the ALU in the same cycle); registers still update at the edge.
//  - Undefined: CRrd/XERrd are pure register outputs; decode stage must interlock one cycle.
// STRUCTURE
//  - CROp_* and CRLogic_* encodings in ctrl_encode_def.v; XER_*_RANGE, XER_IMPL_MASK, CR_WIDTH in SPR_def.v.
//  - One sub-module cr_logic_bit: (a,b,subop)->bit, pure combinational; rest inline next-state logic + two registers.
// TESTING
//  - Reset: drive rst_n low mid-cycle with wbValid=1 -> CRrd=0, XERrd=0 immediately, no write after release.
//  - ADD overflow: caWr=ovWr=1, crOp=REC, aluD=8'b11_100_000 -> XERrd[0:2]=3'b111, CRrd[0:3]=4'b1001.
//  - SO sticky: next cycle ovWr=1, aluD[1]=0 -> OV=0, SO stays 1; then xerWr, gprIn=0 -> SO=0 even with ovWr=1,aluD[1]=1.
//  - MTCRF fxm=8'h81, gprIn=32'hA000_0005, CR=32'hFFFF_FFFF -> CRrd=32'hAFFF_FFF5.
//  - MCRXR crfD=3 with XER[0:3]=4'b1110 and concurrent caWr=1 -> CR[12:15]=4'b1110, XER[0:3]=0.
//  - LOGIC XOR crbA=crbB=crbD=5 with CR[5]=1 -> CR[5]=0; with CRXER_BYPASS_EN, CRrd[5]=0 in same cycle.

Source files
------------

// File: rtl/cr_xer_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr_xer_wb_pkg
// Description : Shared encodings, bit positions and CR field helpers for the
//               CR/XER writeback state unit.
// Revision    : 1.0  initial release
// ============================================================================
package cr_xer_wb_pkg;

  // CR update operation selected at writeback; unlisted codes act as NOP
  typedef enum logic [3:0] {
    CROP_NOP   = 4'd0,
    CROP_REC   = 4'd1,
    CROP_CMP   = 4'd2,
    CROP_MTCRF = 4'd3,
    CROP_MCRF  = 4'd4,
    CROP_MCRXR = 4'd5,
    CROP_LOGIC = 4'd6
  } cr_op_e;

  // CR-logical sub-operation
  typedef enum logic [2:0] {
    CRL_AND  = 3'd0,
    CRL_OR   = 3'd1,
    CRL_XOR  = 3'd2,
    CRL_NAND = 3'd3,
    CRL_NOR  = 3'd4,
    CRL_EQV  = 3'd5,
    CRL_ANDC = 3'd6,
    CRL_ORC  = 3'd7
  } cr_logic_e;

  localparam int C_CR_WIDTH = 32;

  // Architected bit k (big-endian, bit 0 = MSB) lives at vector index 31-k.
  // XER implements SO(0), OV(1), CA(2) and the byte count (25:31).
  localparam logic [C_CR_WIDTH-1:0] C_XER_IMPL_MASK = 32'hE000_007F;
  localparam int C_XER_SO = 31;
  localparam int C_XER_OV = 30;
  localparam int C_XER_CA = 29;

  // ALU flag bus is {CA,OV,LT0,GT0,EQ0,LT,GT,EQ} with CA as the MSB
  localparam int C_ALU_CA  = 7;
  localparam int C_ALU_OV  = 6;
  localparam int C_ALU_LT0 = 5;
  localparam int C_ALU_GT0 = 4;
  localparam int C_ALU_EQ0 = 3;
  localparam int C_ALU_LT  = 2;
  localparam int C_ALU_GT  = 1;
  localparam int C_ALU_EQ  = 0;

  // Read 4-bit field idx; field 0 is the most significant nibble
  function automatic logic [3:0] cr_field_get(input logic [C_CR_WIDTH-1:0] v,
                                              input logic [2:0] idx);
    return v[{~idx, 2'b00} +: 4];
  endfunction

  // Return v with 4-bit field idx replaced by val
  function automatic logic [C_CR_WIDTH-1:0] cr_field_set(input logic [C_CR_WIDTH-1:0] v,
                                                         input logic [2:0] idx,
                                                         input logic [3:0] val);
    logic [C_CR_WIDTH-1:0] r;
    r = v;
    r[{~idx, 2'b00} +: 4] = val;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cr_xer_wb_logic_bit.sv
`default_nettype none
// ============================================================================
// Module      : cr_logic_bit
// Description : Single-bit CR-logical function (a, b, subop) -> y, purely
//               combinational.
// Revision    : 1.0  initial release
// ============================================================================
module cr_logic_bit
  import cr_xer_wb_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  cr_logic_e subop,
  output logic      y
);

  // Evaluate the selected two-input boolean function
  always_comb begin
    y = 1'b0;
    case (subop)
      CRL_AND:  y = a & b;
      CRL_OR:   y = a | b;
      CRL_XOR:  y = a ^ b;
      CRL_NAND: y = ~(a & b);
      CRL_NOR:  y = ~(a | b);
      CRL_EQV:  y = ~(a ^ b);
      CRL_ANDC: y = a & ~b;
      CRL_ORC:  y = a | ~b;
      default:  y = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cr_xer_wb.sv
`default_nettype none
// ============================================================================
// Module      : cr_xer_wb
// Description : Architected CR/XER state at writeback. Latches ALU flags,
//               executes mtcrf/mcrf/mcrxr/mtxer and the CR-logical ops.
//               Optional macro CRXER_BYPASS_EN forwards next-state values
//               combinationally on CRrd/XERrd while wbValid is high.
// Revision    : 1.0  initial release
// ============================================================================
module cr_xer_wb
  import cr_xer_wb_pkg::*;
#(
  parameter logic [31:0] CR_RST  = 32'h0000_0000,
  parameter logic [31:0] XER_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbValid,
  input  logic [7:0]  aluD,
  input  logic [3:0]  crOp,
  input  logic [2:0]  crLogic,
  input  logic        caWr,
  input  logic        ovWr,
  input  logic        xerWr,
  input  logic [2:0]  crfD,
  input  logic [2:0]  crfS,
  input  logic [4:0]  crbA,
  input  logic [4:0]  crbB,
  input  logic [4:0]  crbD,
  input  logic [7:0]  fxm,
  input  logic [31:0] gprIn,
  output logic [31:0] CRrd,
  output logic [31:0] XERrd
);

  logic [C_CR_WIDTH-1:0] r_cr;
  logic [C_CR_WIDTH-1:0] r_xer;
  logic [C_CR_WIDTH-1:0] w_cr_next;
  logic [C_CR_WIDTH-1:0] w_xer_next;
  logic                  w_so_new;
  logic                  w_logic_y;
  cr_op_e                w_op;

  assign w_op = cr_op_e'(crOp);

  // CR bit indices are big-endian, so architected bit k is vector bit ~k
  cr_logic_bit u_logic_bit (
    .a     (r_cr[~crbA]),
    .b     (r_cr[~crbB]),
    .subop (cr_logic_e'(crLogic)),
    .y     (w_logic_y)
  );

  // XER next state: mtxer beats flag writes, SO is sticky, mcrxr clears last
  always_comb begin
    w_xer_next = r_xer;
    if (wbValid) begin
      if (xerWr) begin
        w_xer_next = gprIn & C_XER_IMPL_MASK;
      end else begin
        if (caWr) w_xer_next[C_XER_CA] = aluD[C_ALU_CA];
        if (ovWr) begin
          w_xer_next[C_XER_OV] = aluD[C_ALU_OV];
          w_xer_next[C_XER_SO] = r_xer[C_XER_SO] | aluD[C_ALU_OV];
        end
      end
    end
    // SO as seen by same-cycle CR field writes (includes this cycle's OV)
    w_so_new = w_xer_next[C_XER_SO];
    if (wbValid && (w_op == CROP_MCRXR)) w_xer_next[31:28] = 4'b0000;
  end

  // CR next state: every source field/bit is taken from the old CR value
  always_comb begin
    w_cr_next = r_cr;
    if (wbValid) begin
      case (w_op)
        CROP_REC:
          w_cr_next = cr_field_set(r_cr, 3'd0,
                        {aluD[C_ALU_LT0], aluD[C_ALU_GT0], aluD[C_ALU_EQ0], w_so_new});
        CROP_CMP:
          w_cr_next = cr_field_set(r_cr, crfD,
                        {aluD[C_ALU_LT], aluD[C_ALU_GT], aluD[C_ALU_EQ], w_so_new});
        CROP_MTCRF:
          for (int i = 0; i < 8; i++) begin
            if (fxm[i]) w_cr_next = cr_field_set(w_cr_next, 3'(i), cr_field_get(gprIn, 3'(i)));
          end
        CROP_MCRF:
          w_cr_next = cr_field_set(r_cr, crfD, cr_field_get(r_cr, crfS));
        CROP_MCRXR:
          w_cr_next = cr_field_set(r_cr, crfD, r_xer[31:28]);
        CROP_LOGIC:
          w_cr_next[~crbD] = w_logic_y;
        default: w_cr_next = r_cr;
      endcase
    end
  end

  // State registers; async reset discards any update in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cr  <= CR_RST;
      r_xer <= XER_RST & C_XER_IMPL_MASK;
    end else begin
      r_cr  <= w_cr_next;
      r_xer <= w_xer_next;
    end
  end

`ifdef CRXER_BYPASS_EN
  // Same-cycle forwarding of the pending update; suppressed while in reset
  assign CRrd  = (wbValid && rst_n) ? w_cr_next  : r_cr;
  assign XERrd = (wbValid && rst_n) ? w_xer_next : r_xer;
`else
  assign CRrd  = r_cr;
  assign XERrd = r_xer;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr_xer_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr_xer_wb
// Description : Self-checking bench for cr_xer_wb: directed scenarios plus
//               randomized traffic checked against a bit-level CR/XER model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cr_xer_wb;

  localparam logic [3:0] OP_NOP = 4'd0, OP_REC = 4'd1, OP_CMP = 4'd2, OP_MTCRF = 4'd3,
                         OP_MCRF = 4'd4, OP_MCRXR = 4'd5, OP_LOGIC = 4'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wbValid = 1'b0;
  logic [7:0]  aluD = '0;
  logic [3:0]  crOp = '0;
  logic [2:0]  crLogic = '0;
  logic        caWr = 1'b0, ovWr = 1'b0, xerWr = 1'b0;
  logic [2:0]  crfD = '0, crfS = '0;
  logic [4:0]  crbA = '0, crbB = '0, crbD = '0;
  logic [7:0]  fxm = '0;
  logic [31:0] gprIn = '0;
  logic [31:0] CRrd, XERrd;

  int passed = 0;
  int total  = 0;

  // Reference state: crm[k] is architected CR bit k (0 = leftmost)
  bit       crm [32];
  bit       so, ov, ca;
  bit [6:0] cnt;

  cr_xer_wb dut (
    .clk(clk), .rst_n(rst_n), .wbValid(wbValid), .aluD(aluD), .crOp(crOp),
    .crLogic(crLogic), .caWr(caWr), .ovWr(ovWr), .xerWr(xerWr), .crfD(crfD),
    .crfS(crfS), .crbA(crbA), .crbB(crbB), .crbD(crbD), .fxm(fxm),
    .gprIn(gprIn), .CRrd(CRrd), .XERrd(XERrd)
  );

  always #5 clk = ~clk;

  // Architected bit k of the flag bus / GPR (bit 0 = MSB)
  function automatic bit alu_be(input int k);
    return aluD[7-k];
  endfunction
  function automatic bit gpr_be(input int k);
    return gprIn[31-k];
  endfunction

  function automatic logic [31:0] exp_cr();
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[31-k] = crm[k];
    return r;
  endfunction

  function automatic logic [31:0] exp_xer();
    logic [31:0] r;
    r = '0;
    r[31] = so; r[30] = ov; r[29] = ca; r[6:0] = cnt;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) crm[k] = 1'b0;
    so = 0; ov = 0; ca = 0; cnt = '0;
  endtask

  // Apply one writeback cycle of the architectural rules to the model
  task automatic model_step();
    bit oc [32];
    bit oso, oov, oca, a, b, y;
    int f, s;
    if (!wbValid) return;
    oc = crm; oso = so; oov = ov; oca = ca;
    if (xerWr) begin
      so = gpr_be(0); ov = gpr_be(1); ca = gpr_be(2); cnt = gprIn[6:0];
    end else begin
      if (caWr) ca = alu_be(0);
      if (ovWr) begin ov = alu_be(1); so = so | alu_be(1); end
    end
    f = 4 * int'(crfD);
    s = 4 * int'(crfS);
    case (crOp)
      OP_REC: begin crm[0] = alu_be(2); crm[1] = alu_be(3); crm[2] = alu_be(4); crm[3] = so; end
      OP_CMP: begin crm[f] = alu_be(5); crm[f+1] = alu_be(6); crm[f+2] = alu_be(7); crm[f+3] = so; end
      OP_MTCRF:
        for (int i = 0; i < 8; i++)
          if (fxm[i]) for (int j = 0; j < 4; j++) crm[4*i+j] = gpr_be(4*i+j);
      OP_MCRF: for (int j = 0; j < 4; j++) crm[f+j] = oc[s+j];
      OP_MCRXR: begin
        crm[f] = oso; crm[f+1] = oov; crm[f+2] = oca; crm[f+3] = 1'b0;
        so = 0; ov = 0; ca = 0;
      end
      OP_LOGIC: begin
        a = oc[crbA]; b = oc[crbB];
        case (crLogic)
          3'd0: y = a && b;
          3'd1: y = a || b;
          3'd2: y = a != b;
          3'd3: y = !(a && b);
          3'd4: y = !(a || b);
          3'd5: y = a == b;
          3'd6: y = a && !b;
          default: y = a || !b;
        endcase
        crm[crbD] = y;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Run one cycle with current inputs, then compare both outputs with the model
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1 wbValid = 1'b0;
    #1;
    check({tag, "_cr"}, CRrd, exp_cr());
    check({tag, "_xer"}, XERrd, exp_xer());
  endtask

  task automatic clear_ctl();
    caWr = 0; ovWr = 0; xerWr = 0; crOp = OP_NOP; fxm = '0;
  endtask

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_cr", CRrd, 32'h0);
    check("por_xer", XERrd, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;

    // ADD with carry and overflow, recorded into CR0
    clear_ctl(); wbValid = 1; caWr = 1; ovWr = 1; crOp = OP_REC; aluD = 8'b11_100_000;
    step("add_ov");
    check("add_xer012", {29'd0, XERrd[31:29]}, 32'd7);
    check("add_cr0", {28'd0, CRrd[31:28]}, 32'h9);

    // OV clears, SO sticks
    clear_ctl(); wbValid = 1; ovWr = 1; aluD = 8'b00_000_000;
    step("so_sticky");
    check("so_sticky_bits", {29'd0, XERrd[31:29]}, 32'd5);

    // mtxer clears SO despite a concurrent overflow
    clear_ctl(); wbValid = 1; xerWr = 1; ovWr = 1; gprIn = 32'h0; aluD = 8'b01_000_000;
    step("mtxer_clr");
    check("mtxer_zero", XERrd, 32'h0);

    // Idle cycle with busy inputs must not change state
    clear_ctl(); wbValid = 0; xerWr = 1; crOp = OP_MTCRF; fxm = 8'hFF; gprIn = 32'h1234_5678;
    step("idle");

    // MTCRF: fill, then write fields 0 and 7 only
    clear_ctl(); wbValid = 1; crOp = OP_MTCRF; fxm = 8'hFF; gprIn = 32'hFFFF_FFFF;
    step("mtcrf_all");
    clear_ctl(); wbValid = 1; crOp = OP_MTCRF; fxm = 8'h81; gprIn = 32'hA000_0005;
    step("mtcrf_81");
    check("mtcrf_val", CRrd, 32'hAFFF_FFF5);

    // MCRXR into field 3 with a concurrent CA write
    clear_ctl(); wbValid = 1; xerWr = 1; gprIn = 32'hE000_0000;
    step("set_xer");
    clear_ctl(); wbValid = 1; crOp = OP_MCRXR; crfD = 3'd3; caWr = 1; aluD = 8'b10_000_000;
    step("mcrxr");
    check("mcrxr_cr", CRrd, 32'hAFFE_FFF5);
    check("mcrxr_xer", {28'd0, XERrd[31:28]}, 32'h0);

    // LOGIC XOR with all three indices equal
    clear_ctl(); wbValid = 1; crOp = OP_LOGIC; crLogic = 3'd2;
    crbA = 5'd5; crbB = 5'd5; crbD = 5'd5;
`ifdef CRXER_BYPASS_EN
    #1 check("xor_bypass", {31'd0, CRrd[26]}, 32'd0);
`endif
    step("xor5");
    check("xor5_val", CRrd, 32'hABFE_FFF5);

    // MCRF onto itself leaves the field unchanged
    clear_ctl(); wbValid = 1; crOp = OP_MCRF; crfD = 3'd2; crfS = 3'd2;
    step("mcrf_self");

    // Reset asserted mid-cycle during a pending write
    clear_ctl(); wbValid = 1; xerWr = 1; crOp = OP_MTCRF; fxm = 8'hFF; gprIn = 32'hFFFF_FFFF;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_cr", CRrd, 32'h0);
    check("rst_mid_xer", XERrd, 32'h0);
    wbValid = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    check("rst_rel_cr", CRrd, 32'h0);
    check("rst_rel_xer", XERrd, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      wbValid = ($urandom_range(0, 9) != 0);
      aluD    = 8'($urandom);
      crOp    = 4'($urandom_range(0, 8));
      crLogic = 3'($urandom);
      caWr    = 1'($urandom);
      ovWr    = 1'($urandom);
      xerWr   = ($urandom_range(0, 7) == 0);
      crfD    = 3'($urandom);
      crfS    = 3'($urandom);
      crbA    = 5'($urandom);
      crbB    = 5'($urandom);
      crbD    = 5'($urandom);
      fxm     = 8'($urandom);
      gprIn   = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
